// File: rtl/gbc_dma_pkg.sv
// Shared types and constants for the GBC DMA engines.
package gbc_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dma_state_t;

  localparam int         OAM_LEN  = 160;
  localparam logic [7:0] ECHO_LO  = 8'hE0;
  localparam logic [7:0] ECHO_OFS = 8'h20;

  // Pages E0-FF alias the work RAM at C0-DF.
  function automatic logic [7:0] eff_page(input logic [7:0] page);
    return (page >= ECHO_LO) ? page - ECHO_OFS : page;
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// Source-read and OAM-write bus between the DMA engine (master) and memories (slave).
interface oam_dma_if;
  logic        src_en;
  logic [15:0] src_addr;
  logic [7:0]  src_din;
  logic        dst_en;
  logic        dst_we;
  logic [14:0] dst_addr;
  logic [7:0]  dst_dout;

  modport master (
    output src_en, src_addr, dst_en, dst_we, dst_addr, dst_dout,
    input  src_din
  );

  modport slave (
    input  src_en, src_addr, dst_en, dst_we, dst_addr, dst_dout,
    output src_din
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: FF46 write copies LENGTH bytes from a source page into OAM RAM.
// Optional build macro OAM_DMA_RESTART_EN: a trigger while busy restarts the copy.
module oam_dma
  import gbc_dma_pkg::*;
#(
  parameter int          LENGTH   = OAM_LEN,
  parameter logic [14:0] DST_BASE = 15'h0000
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic        reg_we,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  input  logic        pause,
  output logic        busy,
  oam_dma_if.master   mem
);

  localparam logic [8:0] LAST_IDX = 9'(LENGTH - 1);

  dma_state_t state_reg;
  logic [7:0] page_reg;
  logic [8:0] idx_reg;
  logic       pend_reg;
  logic [7:0] pidx_reg;
  logic       busy_reg;

  logic issue;
  logic trigger;

  assign issue = (state_reg == RUN) && !pause;

`ifdef OAM_DMA_RESTART_EN
  assign trigger = reg_we;
`else
  assign trigger = reg_we && (state_reg == IDLE);
`endif

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_reg <= IDLE;
      page_reg  <= 8'hFF;
      idx_reg   <= 9'd0;
      pend_reg  <= 1'b0;
      pidx_reg  <= 8'd0;
      busy_reg  <= 1'b0;
    end else begin
      // Every issued read becomes a write next cycle, even across a restart.
      pend_reg <= issue;
      if (issue) begin
        pidx_reg <= idx_reg[7:0];
      end

      case (state_reg)
        IDLE: ;
        RUN: begin
          if (issue) begin
            idx_reg <= idx_reg + 9'd1;
            if (idx_reg == LAST_IDX) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      if (trigger) begin
        page_reg  <= reg_din;
        idx_reg   <= 9'd0;
        state_reg <= RUN;
        busy_reg  <= 1'b1;
      end
    end
  end

  // Address/data buses are forced to zero when idle so reset shows all-zero outputs.
  assign mem.src_en   = issue;
  assign mem.src_addr = issue ? {eff_page(page_reg), idx_reg[7:0]} : 16'h0000;
  assign mem.dst_en   = pend_reg;
  assign mem.dst_we   = pend_reg;
  assign mem.dst_addr = pend_reg ? DST_BASE + {7'b0, pidx_reg} : 15'h0000;
  assign mem.dst_dout = pend_reg ? mem.src_din : 8'h00;

  assign reg_dout = page_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: vector table, corner sequences, randomized transfers.
module tb_oam_dma;

  logic       clka = 1'b0;
  logic       rsta = 1'b1;
  logic       reg_we = 1'b0;
  logic [7:0] reg_din = 8'h00;
  logic [7:0] reg_dout;
  logic       pause = 1'b0;
  logic       busy;

  oam_dma_if mem_if ();

  oam_dma #(.LENGTH(160), .DST_BASE(15'h0000)) dut (
    .clka     (clka),
    .rsta     (rsta),
    .reg_we   (reg_we),
    .reg_din  (reg_din),
    .reg_dout (reg_dout),
    .pause    (pause),
    .busy     (busy),
    .mem      (mem_if.master)
  );

  always #5 clka = ~clka;

  logic [7:0] src_mem [0:65535];
  logic [7:0] oam_sh  [0:255];
  logic [7:0] oam_ref [0:255];
  int         wcnt    [0:255];
  bit         pat     [0:511];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Synchronous source memory: data appears the cycle after the request.
  always @(posedge clka) begin
    logic        en;
    logic [15:0] a;
    en = mem_if.src_en;
    a  = mem_if.src_addr;
    #1;
    if (en) mem_if.src_din = src_mem[a];
  end

  // OAM shadow: records every write the engine performs.
  always @(negedge clka) begin
    if (!rsta && mem_if.dst_en && mem_if.dst_we) begin
      oam_sh[mem_if.dst_addr[7:0]] = mem_if.dst_dout;
      wcnt[mem_if.dst_addr[7:0]]   = wcnt[mem_if.dst_addr[7:0]] + 1;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_pat(input int start, input int len);
    for (int i = 0; i < 512; i++) pat[i] = (i >= start) && (i < start + len);
  endtask

  // Busy length from the rules: 160 non-paused read cycles, plus the drain cycle.
  function automatic int model_busy();
    int reads = 0;
    int c = 0;
    while (reads < 160 && c < 400) begin
      if (!pat[c]) reads++;
      c++;
    end
    return c + 1;
  endfunction

  function automatic logic [7:0] model_eff(input logic [7:0] pg);
    return (pg >= 8'hE0) ? pg - 8'h20 : pg;
  endfunction

  // Called between edges; trigger is captured on the next rising edge.
  task automatic xfer(input string nm, input logic [7:0] pg, input logic [7:0] eff,
                      input int exp_busy, input int we_cyc, input logic [7:0] we_val);
    int nb = 0;
    int nrd = 0;
    int nwr = 0;
    bit prev_en = 0;
    bit done = 0;
    reg_din = pg;
    reg_we  = 1'b1;
    @(posedge clka);
    #1 reg_we = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      pause = pat[c];
      if (c == we_cyc) begin
        reg_we  = 1'b1;
        reg_din = we_val;
      end
      @(negedge clka);
      if (busy) nb++;
      chk({nm, " write-follows-read"}, int'(mem_if.dst_we), int'(prev_en));
      if (mem_if.src_en) begin
        chk({nm, " src_addr"}, int'(mem_if.src_addr), int'({eff, nrd[7:0]}));
        nrd++;
      end
      if (mem_if.dst_we) begin
        chk({nm, " dst_addr"}, int'(mem_if.dst_addr), nwr);
        chk({nm, " dst_dout"}, int'(mem_if.dst_dout), int'(src_mem[{eff, nwr[7:0]}]));
        nwr++;
      end
      prev_en = mem_if.src_en;
      if (!busy) begin
        done = 1;
      end else begin
        @(posedge clka);
        #1 reg_we = 1'b0;
      end
    end
    pause  = 1'b0;
    reg_we = 1'b0;
    chk({nm, " completed"}, int'(done), 1);
    chk({nm, " busy cycles"}, nb, exp_busy);
    chk({nm, " reads"}, nrd, 160);
    chk({nm, " writes"}, nwr, 160);
    chk({nm, " reg_dout"}, int'(reg_dout), int'(pg));
    $display("xfer %s page=%02h busy=%0d reads=%0d writes=%0d", nm, pg, nb, nrd, nwr);
  endtask

  typedef struct {
    logic [7:0] pg;
    logic [7:0] eff;
    int         ps;
    int         pl;
    int         busy_exp;
  } vec_t;

  vec_t vt [0:6];

  initial begin
    int sum;
    logic [7:0] pg;

    vt[0] = '{8'hC1, 8'hC1,   0, 0, 161};  // basic copy
    vt[1] = '{8'hC1, 8'hC1,  40, 5, 166};  // pause at idx 40
    vt[2] = '{8'hE3, 8'hC3,   0, 0, 161};  // echo page
    vt[3] = '{8'hFF, 8'hDF,   0, 3, 164};  // pause from the first cycle
    vt[4] = '{8'hE0, 8'hC0, 159, 2, 163};  // pause on the last read
    vt[5] = '{8'hDF, 8'hDF, 160, 4, 161};  // pause only in drain/idle
    vt[6] = '{8'h00, 8'h00,   1, 1, 162};

    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
    for (int i = 0; i < 160; i++) src_mem[16'hC100 + i] = 8'(i);
    for (int i = 0; i < 256; i++) begin
      oam_sh[i] = 8'h00;
      wcnt[i]   = 0;
    end

    repeat (2) @(posedge clka);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset src_en", int'(mem_if.src_en), 0);
    chk("reset dst_en", int'(mem_if.dst_en), 0);
    chk("reset dst_we", int'(mem_if.dst_we), 0);
    chk("reset src_addr", int'(mem_if.src_addr), 0);
    chk("reset dst_addr", int'(mem_if.dst_addr), 0);
    chk("reset dst_dout", int'(mem_if.dst_dout), 0);
    chk("reset reg_dout", int'(reg_dout), 8'hFF);
    rsta = 1'b0;
    @(negedge clka);

    for (int i = 0; i < 7; i++) begin
      set_pat(vt[i].ps, vt[i].pl);
      xfer($sformatf("vec%0d", i), vt[i].pg, vt[i].eff, vt[i].busy_exp, -1, 8'h00);
      if (i == 0) begin
        for (int k = 0; k < 160; k++) begin
          chk($sformatf("basic oam[%0d]", k), int'(oam_sh[k]), k);
          oam_ref[k] = oam_sh[k];
        end
      end
      if (i == 1) begin
        for (int k = 0; k < 160; k++)
          chk($sformatf("pause oam[%0d]", k), int'(oam_sh[k]), int'(oam_ref[k]));
      end
    end

`ifndef OAM_DMA_RESTART_EN
    // Write at idx 50 must be ignored: copy continues from page C1.
    set_pat(0, 0);
    xfer("busy_we", 8'hC1, 8'hC1, 161, 50, 8'hC2);
`endif

    // Back-to-back: second trigger lands in the first idle cycle.
    for (int i = 0; i < 256; i++) wcnt[i] = 0;
    set_pat(0, 0);
    xfer("b2b_a", 8'hC4, 8'hC4, 161, -1, 8'h00);
    chk("b2b first final write", int'(wcnt[159]), 1);
    chk("b2b first final data", int'(oam_sh[159]), int'(src_mem[16'hC49F]));
    xfer("b2b_b", 8'hC5, 8'hC5, 161, -1, 8'h00);
    chk("b2b final write count", int'(wcnt[159]), 2);

    // Asynchronous reset during the read of idx 80.
    for (int i = 0; i < 256; i++) wcnt[i] = 0;
    reg_din = 8'hC1;
    reg_we  = 1'b1;
    @(posedge clka);
    #1 reg_we = 1'b0;
    repeat (80) @(posedge clka);
    #1;
    chk("rst pre busy", int'(busy), 1);
    chk("rst pre src_addr", int'(mem_if.src_addr), 16'hC150);
    #1 rsta = 1'b1;
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst src_en", int'(mem_if.src_en), 0);
    chk("rst dst_we", int'(mem_if.dst_we), 0);
    chk("rst dst_addr", int'(mem_if.dst_addr), 0);
    chk("rst reg_dout", int'(reg_dout), 8'hFF);
    reg_din = 8'hC7;
    reg_we  = 1'b1;
    @(posedge clka);
    #1 reg_we = 1'b0;
    @(posedge clka);
    #1 rsta = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clka);
      chk("post-rst dst_we", int'(mem_if.dst_we), 0);
      chk("post-rst busy", int'(busy), 0);
    end
    chk("rst ignored reg_we", int'(reg_dout), 8'hFF);
    sum = 0;
    for (int k = 80; k < 160; k++) sum += wcnt[k];
    chk("rst oam 80..159 untouched", sum, 0);
    sum = 0;
    for (int k = 0; k < 79; k++) sum += wcnt[k];
    chk("rst oam 0..78 written", sum, 79);
    $display("reset sequence done");

    // Randomized pages and pause patterns.
    for (int t = 0; t < 12; t++) begin
      pg = 8'($urandom);
      for (int i = 0; i < 512; i++) pat[i] = ($urandom_range(0, 3) == 0);
      xfer($sformatf("rand%0d", t), pg, model_eff(pg), model_busy(), -1, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
